motor_decode: RTL
=================

# motor_decode

Decoder for the drive-side PWM interface: samples the four motor direction/PWM lines (fwd_lft, rev_lft, fwd_rht, rev_rht) and reconstructs signed 11-bit left/right drive commands. It measures high time over back-to-back windows of one PWM period (2^PERIOD_BITS cycles). It sits on the motor outputs as a loop-back/self-check monitor and feeds the test and telemetry logic.

## Interface
- PERIOD_BITS, 10, log2 of PWM period in clk cycles; window = 2^PERIOD_BITS samples
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  measurement enable; sampled each clk
- fwd_lft, rev_lft  input  1 each  left forward/reverse PWM lines, same clock domain
- fwd_rht, rev_rht  input  1 each  right forward/reverse PWM lines, same clock domain
- lft_out  output  PERIOD_BITS+1  signed decoded left command, two's complement
- rht_out  output  PERIOD_BITS+1  signed decoded right command, two's complement
- vld  output  1  one-cycle pulse: lft_out/rht_out updated this cycle
- conflict  output  1  sticky: fwd and rev of the same side both high in one sample, or both nonzero in one window
- sat  output  1  sticky: a line was high for every sample of a window

## Operation
- FSM states: IDLE, MEAS.
- Reset (rst=1 at an edge): state=IDLE, window counter=0, all four high-counters=0, lft_out=0, rht_out=0, vld=0, conflict=0, sat=0. rst overrides en and every other input.
- IDLE: counters held at 0. If en=1 at an edge, go to MEAS with win_cnt=0.
- MEAS, each edge: sample all four lines. Each high-counter (PERIOD_BITS+1 bits) increments when its line is 1. win_cnt increments.
- Window end (edge where win_cnt = 2^PERIOD_BITS-1, including that edge's sample) latches results per side. F and R are the final counts, with the last sample included.
  - F>0, R=0 → out = +min(F, 2^PERIOD_BITS-1)
  - R>0, F=0 → out = -min(R, 2^PERIOD_BITS-1)
  - F=R=0 → out = 0
  - F>0 and R>0 → out holds its previous value; set conflict
  - Any count = 2^PERIOD_BITS → set sat; value clamps to ±(2^PERIOD_BITS-1)
- At window end, vld=1 for the next cycle. All counters clear, so the next window starts on the next edge with no gap. The next state is MEAS if en=1, else IDLE.
- en=0 mid-window: abort. Go to IDLE, clear counters, no vld, outputs hold.
- A per-sample fwd&rev=1 on the same side sets conflict immediately. The sample still counts toward both counters.
- conflict and sat clear only on rst.
- Output range: -(2^PERIOD_BITS-1) .. +(2^PERIOD_BITS-1). The most negative code is never produced.

## Timing
- Edge t0: en=1 sampled in IDLE.
- Window samples: edges t1..t(2^PERIOD_BITS).
- Results are registered at edge t(2^PERIOD_BITS). They are visible with vld=1 in the following cycle. Latency from first sample to vld = 2^PERIOD_BITS cycles.
- With en held high, vld pulses every 2^PERIOD_BITS cycles exactly.
- Measurement is phase-independent. Any window of a steady PWM with duty d yields exactly d.
- A change in the encoder command settles after at most 2 windows. One mixed window may appear in between.
- Outputs are registered, with no combinational path from inputs.

## Test plan
- Reset with en=1, all lines 0: outputs 0, vld=0, flags 0. Release rst; first vld appears 1025 cycles after the en sample, with lft_out=0 and rht_out=0.
- fwd_lft PWM duty 300, rev_rht PWM duty 512, arbitrary phase: each vld gives lft_out=+300 and rht_out=-512 (0x600). Successive vld pulses are exactly 1024 cycles apart.
- fwd_rht held 1 constantly: rht_out=+1023, sat=1 and sticky through later normal windows until rst.
- fwd_lft and rev_lft both 1 for one cycle inside a window: conflict=1 that cycle onward. lft_out keeps its prior value at window end; rht_out still updates.
- Drop en at sample 500 of a window, then restart: no vld for the aborted window, outputs unchanged. The next vld appears 1025 cycles after en re-asserts.
- Assert rst mid-window with nonzero outputs and flags: all outputs 0 next cycle, state IDLE, no vld.

Source files
------------

// File: rtl/motor_decode.sv
// ---------------------------------------------------------------------------
// motor_decode
//   Loop-back monitor for the drive-side PWM outputs. Counts the high time of
//   the four motor lines over back-to-back windows of one PWM period
//   (2^PERIOD_BITS samples) and rebuilds signed left/right drive commands.
//
// Ports
//   i_clk                  system clock, rising edge
//   i_rst                  synchronous active-high reset
//   i_en                   measurement enable (dropping it mid-window aborts)
//   i_fwd_lft, i_rev_lft   left forward/reverse PWM lines
//   i_fwd_rht, i_rev_rht   right forward/reverse PWM lines
//   o_lft_out, o_rht_out   signed decoded commands, +/-(2^PERIOD_BITS-1)
//   o_vld                  one-cycle pulse, outputs updated this cycle
//   o_conflict             sticky: fwd and rev of one side active together
//   o_sat                  sticky: a line was high for a whole window
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// motor_side_dec
//   Per-side high-time counters and command register. The top-level FSM tells
//   it when a sample counts (i_smp) and when that sample closes the window
//   (i_win_end). Flag events come out combinationally and are made sticky in
//   the top level.
//
// Ports
//   i_clk, i_rst      clock / synchronous reset
//   i_smp             this edge's sample belongs to the running window
//   i_win_end         this edge's sample is the last of the window
//   i_fwd, i_rev      forward / reverse PWM line of this side
//   o_cmd             registered signed command (two's complement)
//   o_conf_smp        fwd and rev both high in a counted sample
//   o_conf_win        both counts nonzero at window end
//   o_sat_win         a count reached a full window at window end
// ---------------------------------------------------------------------------
module motor_side_dec #(
   parameter int PERIOD_BITS = 10
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_smp,
   input  logic                 i_win_end,
   input  logic                 i_fwd,
   input  logic                 i_rev,
   output logic [PERIOD_BITS:0] o_cmd,
   output logic                 o_conf_smp,
   output logic                 o_conf_win,
   output logic                 o_sat_win
);
   localparam int            CW   = PERIOD_BITS + 1;
   localparam logic [CW-1:0] FULL = {1'b1, {PERIOD_BITS{1'b0}}};
   localparam logic [CW-1:0] MAXV = {1'b0, {PERIOD_BITS{1'b1}}};

   logic [CW-1:0] r_f_cnt;
   logic [CW-1:0] r_r_cnt;
   logic [CW-1:0] r_cmd;

   logic [CW-1:0] w_f_nxt;
   logic [CW-1:0] w_r_nxt;
   logic [CW-1:0] w_f_clip;
   logic [CW-1:0] w_r_clip;
   logic          w_f_any;
   logic          w_r_any;

   // Counts including the current sample, so the window-end decision sees
   // the last sample without an extra pipeline stage.
   always_comb begin
      w_f_nxt  = r_f_cnt + CW'(i_fwd);
      w_r_nxt  = r_r_cnt + CW'(i_rev);
      // A full-window count would be 2^PERIOD_BITS; clamp it to keep the
      // result symmetric and never emit the most negative code.
      w_f_clip = (w_f_nxt == FULL) ? MAXV : w_f_nxt;
      w_r_clip = (w_r_nxt == FULL) ? MAXV : w_r_nxt;
   end

   assign w_f_any    = |w_f_nxt;
   assign w_r_any    = |w_r_nxt;
   assign o_conf_smp = i_smp & i_fwd & i_rev;
   assign o_conf_win = i_smp & i_win_end & w_f_any & w_r_any;
   assign o_sat_win  = i_smp & i_win_end & ((w_f_nxt == FULL) | (w_r_nxt == FULL));
   assign o_cmd      = r_cmd;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_f_cnt <= '0;
         r_r_cnt <= '0;
         r_cmd   <= '0;
      end else begin
         // Counters only run inside a window; window end, abort and idle
         // all leave them cleared so the next window starts with no gap.
         if (i_smp && !i_win_end) begin
            r_f_cnt <= w_f_nxt;
            r_r_cnt <= w_r_nxt;
         end else begin
            r_f_cnt <= '0;
            r_r_cnt <= '0;
         end

         // Both directions active in one window is ambiguous: keep the old
         // command (the conflict flag reports it).
         if (i_smp && i_win_end) begin
            if (w_f_any && !w_r_any)
               r_cmd <= w_f_clip;
            else if (w_r_any && !w_f_any)
               r_cmd <= ~w_r_clip + CW'(1);
            else if (!w_f_any && !w_r_any)
               r_cmd <= '0;
         end
      end
   end
endmodule

module motor_decode #(
   parameter int PERIOD_BITS = 10
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_en,
   input  logic                        i_fwd_lft,
   input  logic                        i_rev_lft,
   input  logic                        i_fwd_rht,
   input  logic                        i_rev_rht,
   output logic signed [PERIOD_BITS:0] o_lft_out,
   output logic signed [PERIOD_BITS:0] o_rht_out,
   output logic                        o_vld,
   output logic                        o_conflict,
   output logic                        o_sat
);
   localparam int NUM_SIDES = 2;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MEAS = 1'b1
   } state_t;

   state_t                 r_state;
   logic [PERIOD_BITS-1:0] r_win_cnt;
   logic                   r_vld;
   logic                   r_conflict;
   logic                   r_sat;

   logic                                    w_last;
   logic                                    w_smp;
   logic                                    w_win_end;
   logic [NUM_SIDES-1:0]                    w_fwd;
   logic [NUM_SIDES-1:0]                    w_rev;
   logic [NUM_SIDES-1:0][PERIOD_BITS:0]     w_cmd;
   logic [NUM_SIDES-1:0]                    w_conf_smp;
   logic [NUM_SIDES-1:0]                    w_conf_win;
   logic [NUM_SIDES-1:0]                    w_sat_win;

   // Side 0 = left, side 1 = right.
   assign w_fwd = {i_fwd_rht, i_fwd_lft};
   assign w_rev = {i_rev_rht, i_rev_lft};

   assign w_last    = &r_win_cnt;
   assign w_win_end = (r_state == S_MEAS) & w_last;
   // The closing sample of a window completes even if en falls on that
   // edge; anywhere else en=0 aborts and the sample is discarded.
   assign w_smp     = (r_state == S_MEAS) & (i_en | w_last);

   for (genvar g = 0; g < NUM_SIDES; g++) begin : g_side
      motor_side_dec #(
         .PERIOD_BITS (PERIOD_BITS)
      ) u_side (
         .i_clk      (i_clk),
         .i_rst      (i_rst),
         .i_smp      (w_smp),
         .i_win_end  (w_win_end),
         .i_fwd      (w_fwd[g]),
         .i_rev      (w_rev[g]),
         .o_cmd      (w_cmd[g]),
         .o_conf_smp (w_conf_smp[g]),
         .o_conf_win (w_conf_win[g]),
         .o_sat_win  (w_sat_win[g])
      );
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_win_cnt  <= '0;
         r_vld      <= 1'b0;
         r_conflict <= 1'b0;
         r_sat      <= 1'b0;
      end else begin
         r_vld      <= 1'b0;
         r_conflict <= r_conflict | (|w_conf_smp) | (|w_conf_win);
         r_sat      <= r_sat | (|w_sat_win);

         case (r_state)
            S_IDLE: begin
               r_win_cnt <= '0;
               if (i_en)
                  r_state <= S_MEAS;
            end
            S_MEAS: begin
               if (w_last) begin
                  r_vld     <= 1'b1;
                  r_win_cnt <= '0;
                  r_state   <= i_en ? S_MEAS : S_IDLE;
               end else if (!i_en) begin
                  r_win_cnt <= '0;
                  r_state   <= S_IDLE;
               end else begin
                  r_win_cnt <= r_win_cnt + 1'b1;
               end
            end
            default: begin
               r_win_cnt <= '0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign o_lft_out  = $signed(w_cmd[0]);
   assign o_rht_out  = $signed(w_cmd[1]);
   assign o_vld      = r_vld;
   assign o_conflict = r_conflict;
   assign o_sat      = r_sat;
endmodule
